gate_sequencer: RTL and testbench

Parametrised burst sequencer driving the gate array's transmit/receive handshake. After a start request it issues one sync phase and one load phase, then runs a programmable number of gate clock steps. Each step waits until every enabled gate reports TX and RX ready. It adds per-gate enable masking, a ready-wait timeout with an error state, abort, and step/done status. It sits between the host control registers and the gate array, one instance per array.

---
 rtl/gate_seq_pkg.sv | 27 ++
 rtl/gate_wait_timer.sv | 34 +++
 rtl/gate_sequencer.sv | 144 ++++++++++++++
 tb/tb_gate_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types, default sizes and the gate readiness reduction for gate_sequencer.
package gate_seq_pkg;

    localparam int unsigned GateNumberDefault = 8;
    localparam int unsigned CycleWDefault     = 16;
    localparam int unsigned TimeoutWDefault   = 12;

    // Widest gate array the readiness helper accepts; narrower vectors are zero-extended.
    localparam int unsigned MaxGates = 64;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StWait = 3'd2,
        StStep = 3'd3,
        StDone = 3'd4,
        StErr  = 3'd5
    } gate_state_e;

    // Zero-extended mask bits read as "not participating", so padding is always ready.
    function automatic logic all_ready(input logic [MaxGates-1:0] tx,
                                       input logic [MaxGates-1:0] rx,
                                       input logic [MaxGates-1:0] mask);
        return &((tx & rx) | ~mask);
    endfunction

endpackage

// File: rtl/gate_wait_timer.sv
// Ready-wait counter: expires on the cycle it reaches limit-1; a zero limit never expires.
module gate_wait_timer #(
    parameter int unsigned TIMEOUT_W = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [TIMEOUT_W-1:0] i_limit,
    output logic                 o_expire
);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (i_limit != '0) && (cnt_q == i_limit - TIMEOUT_W'(1));

endmodule

// File: rtl/gate_sequencer.sv
// Burst sequencer for the gate array: sync, load, then gated clock steps paced by TX/RX ready.
module gate_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned GATE_NUMBER = GateNumberDefault,
    parameter int unsigned CYCLE_W     = CycleWDefault,
    parameter int unsigned TIMEOUT_W   = TimeoutWDefault
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [CYCLE_W-1:0]     i_cycles,
    input  logic [GATE_NUMBER-1:0] i_gate_mask,
    input  logic [TIMEOUT_W-1:0]   i_timeout,
    input  logic [GATE_NUMBER-1:0] i_tx_ready,
    input  logic [GATE_NUMBER-1:0] i_rx_ready,
    output logic                   o_gen_sync,
    output logic                   o_tx_start,
    output logic                   o_rx_pull,
    output logic                   o_clock,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [CYCLE_W-1:0]     o_step_count
);

    gate_state_e state_q, state_d;

    logic [CYCLE_W-1:0]     cycles_q;
    logic [GATE_NUMBER-1:0] mask_q;
    logic [TIMEOUT_W-1:0]   timeout_q;
    logic [CYCLE_W-1:0]     step_cnt_q, step_cnt_next;

    logic capture;
    logic step_inc;
    logic timer_clear;
    logic timer_en;
    logic timer_expire;
    logic ready_all;

    assign step_cnt_next = step_cnt_q + CYCLE_W'(1);
    assign ready_all     = all_ready(MaxGates'(i_tx_ready), MaxGates'(i_rx_ready),
                                     MaxGates'(mask_q));

    gate_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (timer_clear),
        .i_enable (timer_en),
        .i_limit  (timeout_q),
        .o_expire (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        step_inc    = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    capture = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                timer_clear = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                // Ready wins over an expiry landing in the same cycle.
                if (ready_all) begin
                    state_d = StStep;
                end else if (timer_expire) begin
                    state_d = StErr;
                end else begin
                    timer_en = 1'b1;
                end
            end
            StStep: begin
                step_inc    = 1'b1;
                timer_clear = 1'b1;
                if ((cycles_q != '0) && (step_cnt_next == cycles_q)) begin
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                if (i_abort) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything and freezes the step count where it stands.
        if (i_abort && (state_q inside {StLoad, StWait, StStep, StDone})) begin
            state_d  = StIdle;
            step_inc = 1'b0;
            timer_en = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cycles_q   <= '0;
            mask_q     <= '0;
            timeout_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cycles_q   <= i_cycles;
                mask_q     <= i_gate_mask;
                timeout_q  <= i_timeout;
                step_cnt_q <= '0;
            end else if (step_inc) begin
                step_cnt_q <= step_cnt_next;
            end
        end
    end

    assign o_gen_sync   = (state_q == StIdle);
    assign o_tx_start   = (state_q == StLoad) || (state_q == StStep);
    assign o_rx_pull    = (state_q == StStep);
    assign o_clock      = (state_q == StStep);
    assign o_busy       = (state_q == StLoad) || (state_q == StWait) || (state_q == StStep);
    assign o_done       = (state_q == StDone);
    assign o_error      = (state_q == StErr);
    assign o_step_count = step_cnt_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Self-checking bench for gate_sequencer: per-scenario tasks plus a step/done event scoreboard.
module tb_gate_sequencer;

    localparam int unsigned GN = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned TW = 12;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [CW-1:0] i_cycles = '0;
    logic [GN-1:0] i_gate_mask = '0;
    logic [TW-1:0] i_timeout = '0;
    logic [GN-1:0] i_tx_ready = '0;
    logic [GN-1:0] i_rx_ready = '0;
    logic          o_gen_sync, o_tx_start, o_rx_pull, o_clock, o_busy, o_done, o_error;
    logic [CW-1:0] o_step_count;

    gate_sequencer #(
        .GATE_NUMBER (GN),
        .CYCLE_W     (CW),
        .TIMEOUT_W   (TW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_cycles     (i_cycles),
        .i_gate_mask  (i_gate_mask),
        .i_timeout    (i_timeout),
        .i_tx_ready   (i_tx_ready),
        .i_rx_ready   (i_rx_ready),
        .o_gen_sync   (o_gen_sync),
        .o_tx_start   (o_tx_start),
        .o_rx_pull    (o_rx_pull),
        .o_clock      (o_clock),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_step_count (o_step_count)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int at_cyc;
        int count;
    } ev_t;

    ev_t exp_q[$];

    // {gen_sync, tx_start, rx_pull, clock, busy, done, error}
    logic [6:0] outs;
    assign outs = {o_gen_sync, o_tx_start, o_rx_pull, o_clock, o_busy, o_done, o_error};

    // Scoreboard: every STEP or DONE cycle must match the next expected event.
    always @(negedge i_clk) begin
        if (!i_rst && (o_clock || o_done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d clock=%b done=%b count=%0d required none",
                         cyc, o_clock, o_done, o_step_count);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (o_done !== e.is_done || cyc != e.at_cyc || o_step_count !== CW'(e.count)) begin
                    errors++;
                    $display("FAIL event done=%b cyc=%0d count=%0d required done=%b cyc=%0d count=%0d",
                             o_done, cyc, o_step_count, e.is_done, e.at_cyc, e.count);
                end
            end
        end
    end

    task automatic push_steps(input int base, input int first_k, input int last_k);
        for (int k = first_k; k <= last_k; k++) begin
            exp_q.push_back('{is_done: 1'b0, at_cyc: base + 2 * k, count: k - 1});
        end
    endtask

    task automatic start_burst(input int cycles, input logic [GN-1:0] mask, input int tmo,
                               output int base);
        @(negedge i_clk);
        i_cycles    = CW'(cycles);
        i_gate_mask = mask;
        i_timeout   = TW'(tmo);
        i_start     = 1'b1;
        base        = cyc + 1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_events pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge i_clk);
        checks++;
        if (outs !== 7'b1000000 || o_step_count !== '0) begin
            errors++;
            $display("FAIL reset_values outs=%b count=%0d required outs=1000000 count=0",
                     outs, o_step_count);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_burst();
        int base;
        i_tx_ready = '1;
        i_rx_ready = '1;
        start_burst(3, 8'hFF, 0, base);
        // Changes after capture must not affect the running burst.
        i_cycles  = CW'(1);
        i_timeout = TW'(1);
        checks++;
        if (outs !== 7'b0100100) begin
            errors++;
            $display("FAIL burst_load outs=%b required 0100100", outs);
        end
        push_steps(base, 1, 3);
        exp_q.push_back('{is_done: 1'b1, at_cyc: base + 7, count: 3});
        repeat (8) @(negedge i_clk);
        checks++;
        if (outs !== 7'b1000000 || o_step_count !== CW'(3)) begin
            errors++;
            $display("FAIL burst_idle outs=%b count=%0d required outs=1000000 count=3",
                     outs, o_step_count);
        end
        check_queue_empty("burst");
    endtask

    task automatic test_mask();
        int base;
        i_tx_ready = 8'hDF;
        i_rx_ready = 8'hDF;
        start_burst(2, 8'h0F, 0, base);
        push_steps(base, 1, 2);
        exp_q.push_back('{is_done: 1'b1, at_cyc: base + 5, count: 2});
        repeat (6) @(negedge i_clk);
        checks++;
        if (outs !== 7'b1000000 || o_step_count !== CW'(2)) begin
            errors++;
            $display("FAIL mask_idle outs=%b count=%0d required outs=1000000 count=2",
                     outs, o_step_count);
        end
        check_queue_empty("mask");
    endtask

    task automatic test_timeout();
        int base;
        i_tx_ready = 8'hFF;
        i_rx_ready = 8'hFE;
        start_burst(3, 8'hFF, 4, base);
        for (int i = 1; i <= 4; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_busy !== 1'b1 || o_error !== 1'b0 || o_clock !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d busy=%b error=%b clock=%b required 1 0 0",
                         i, o_busy, o_error, o_clock);
            end
        end
        @(negedge i_clk);
        checks++;
        if (outs !== 7'b0000001) begin
            errors++;
            $display("FAIL timeout_err outs=%b required 0000001", outs);
        end
        i_start = 1'b1;
        repeat (3) @(negedge i_clk);
        i_start = 1'b0;
        checks++;
        if (outs !== 7'b0000001) begin
            errors++;
            $display("FAIL timeout_hold outs=%b required 0000001", outs);
        end
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        checks++;
        if (outs !== 7'b1000000 || o_step_count !== '0) begin
            errors++;
            $display("FAIL timeout_abort outs=%b count=%0d required outs=1000000 count=0",
                     outs, o_step_count);
        end
        check_queue_empty("timeout");
    endtask

    task automatic test_ready_vs_timeout();
        int base;
        i_tx_ready = 8'hFF;
        i_rx_ready = 8'hFE;
        start_burst(1, 8'hFF, 2, base);
        exp_q.push_back('{is_done: 1'b0, at_cyc: base + 3, count: 0});
        exp_q.push_back('{is_done: 1'b1, at_cyc: base + 4, count: 1});
        repeat (2) @(negedge i_clk);
        // Ready returns exactly on the cycle the timer expires.
        i_rx_ready = 8'hFF;
        @(negedge i_clk);
        checks++;
        if (o_clock !== 1'b1 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL race_step clock=%b error=%b required 1 0", o_clock, o_error);
        end
        repeat (2) @(negedge i_clk);
        checks++;
        if (outs !== 7'b1000000 || o_step_count !== CW'(1)) begin
            errors++;
            $display("FAIL race_idle outs=%b count=%0d required outs=1000000 count=1",
                     outs, o_step_count);
        end
        check_queue_empty("race");
    endtask

    task automatic test_free_run_abort();
        int base;
        i_tx_ready = '1;
        i_rx_ready = '1;
        start_burst(0, 8'hFF, 0, base);
        push_steps(base, 1, 10);
        repeat (21) @(negedge i_clk);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        checks++;
        if (outs !== 7'b1000000 || o_step_count !== CW'(10)) begin
            errors++;
            $display("FAIL freerun_abort outs=%b count=%0d required outs=1000000 count=10",
                     outs, o_step_count);
        end
        repeat (3) @(negedge i_clk);
        check_queue_empty("freerun");
    endtask

    task automatic test_async_reset();
        int base;
        i_tx_ready = '1;
        i_rx_ready = '1;
        start_burst(0, 8'hFF, 0, base);
        push_steps(base, 1, 5);
        repeat (11) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b1 || o_clock !== 1'b0 || o_step_count !== CW'(5)) begin
            errors++;
            $display("FAIL areset_pre busy=%b clock=%b count=%0d required 1 0 5",
                     o_busy, o_clock, o_step_count);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if (outs !== 7'b1000000 || o_step_count !== '0) begin
            errors++;
            $display("FAIL areset_now outs=%b count=%0d required outs=1000000 count=0",
                     outs, o_step_count);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (outs !== 7'b1000000 || o_step_count !== '0) begin
            errors++;
            $display("FAIL areset_after outs=%b count=%0d required outs=1000000 count=0",
                     outs, o_step_count);
        end
        check_queue_empty("areset");
    endtask

    initial begin
        test_reset();
        test_burst();
        test_mask();
        test_timeout();
        test_ready_vs_timeout();
        test_free_run_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a task stalls on the clock.
    initial begin
        #20000;
        $display("FAIL watchdog time=%0t required finish before 20000", $time);
        $fatal(1);
    end

endmodule
